// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: req/ack data-memory bus between the memory-access stage and data memory
interface mem_access_stage_if #(
  parameter int WIDTH = 64
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic [WIDTH-1:0] rdata;
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: resolves branches, runs loads/stores over a req/ack bus, emits a registered write-back bundle
module mem_access_stage #(
  parameter int WIDTH    = 64,
  parameter int TIMEOUT  = 16,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [WIDTH-1:0]    write_data,
  input  logic [WIDTH-1:0]    branch_target,
  input  logic                zero,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                branch,
  input  logic                uncond_branch,
  input  logic                mem_to_reg,
  input  logic                reg_write,
  input  logic [REG_BITS-1:0] rd,
  mem_access_stage_if.master  dmem,
  output logic                pc_src,
  output logic [WIDTH-1:0]    pc_target,
  output logic                wb_valid,
  output logic [WIDTH-1:0]    wb_data,
  output logic [REG_BITS-1:0] wb_rd,
  output logic                wb_reg_write,
  output logic                mem_fault
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic we_q, m2r_q, rw_q;
  logic [REG_BITS-1:0] rd_q;
  logic accept, is_mem, aligned, done;
  assign accept  = ex_valid & ex_ready;
  assign is_mem  = mem_read | mem_write;
  assign aligned = alu_result[2:0] == 3'd0;
  assign done    = dmem.ack | (cnt == LAST);
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  // state register; async reset aborts any in-flight access
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  // aligned memory ops enter ACCESS; ack or expiry returns to IDLE
  always_comb
    next_state = state == IDLE ? ((accept && is_mem && aligned) ? ACCESS : IDLE)
                               : (done ? IDLE : ACCESS);
  // handshake outputs decoded from state; store strobe only meaningful during a request
  always_comb begin
    ex_ready = state == IDLE;
    dmem.req = state == ACCESS;
    dmem.we  = (state == ACCESS) & we_q;
  end
  // latch the accepted instruction, resolve its branch, produce write-back and fault flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      m2r_q        <= 1'b0;
      rw_q         <= 1'b0;
      rd_q         <= '0;
      pc_src       <= 1'b0;
      pc_target    <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      mem_fault    <= 1'b0;
    end else begin
      pc_src       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      if (accept) begin
        addr_q    <= alu_result;
        wdata_q   <= write_data;
        we_q      <= mem_write;
        m2r_q     <= mem_to_reg;
        rw_q      <= reg_write;
        rd_q      <= rd;
        pc_src    <= uncond_branch | (branch & zero);
        pc_target <= branch_target;
        if (is_mem && !aligned) mem_fault <= 1'b1;
        else if (!is_mem) begin
          wb_valid     <= 1'b1;
          wb_data      <= alu_result;
          wb_rd        <= rd;
          wb_reg_write <= reg_write;
        end
      end
      if (state == ACCESS) begin
        cnt <= done ? '0 : cnt + 1'b1;
        if (dmem.ack) begin
          wb_valid     <= 1'b1;
          wb_data      <= m2r_q ? dmem.rdata : addr_q;
          wb_rd        <= rd_q;
          wb_reg_write <= rw_q;
        end else if (cnt == LAST) mem_fault <= 1'b1;
      end
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result, store data, branch target and zero flag.
- Resolves conditional and unconditional branches.
- Performs loads and stores over a multi-cycle req/ack data-memory bus, then presents a registered write-back bundle.
- Stalls upstream while a memory access is outstanding.

Parameters:
WIDTH, `WORD (64), datapath width for addresses and data
TIMEOUT, 16, max cycles dmem_req may wait for dmem_ack before a fault
REG_BITS, 5, width of destination register index

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
ex_valid  in  1  execute stage presents an instruction this cycle
ex_ready  out  1  stage can accept; high only in IDLE
alu_result  in  WIDTH  ALU result; effective address for loads/stores
write_data  in  WIDTH  store data (register read port 2)
branch_target  in  WIDTH  computed branch target
zero  in  1  ALU zero flag
mem_read  in  1  instruction is a load
mem_write  in  1  instruction is a store
branch  in  1  conditional branch (taken when zero=1)
uncond_branch  in  1  unconditional branch
mem_to_reg  in  1  write-back selects load data instead of ALU result
reg_write  in  1  instruction writes a register
rd  in  REG_BITS  destination register index
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = store, 0 = load; valid with dmem_req
dmem_addr  out  WIDTH  byte address
dmem_wdata  out  WIDTH  store data
dmem_ack  in  1  memory completes the request this cycle
dmem_rdata  in  WIDTH  load data, valid with dmem_ack
pc_src  out  1  one-cycle pulse: branch taken
pc_target  out  WIDTH  target for the fetch stage, valid with pc_src
wb_valid  out  1  one-cycle pulse: write-back bundle valid
wb_data  out  WIDTH  load data or ALU result
wb_rd  out  REG_BITS  destination index
wb_reg_write  out  1  register write enable, gated by wb_valid
mem_fault  out  1  sticky fault flag, cleared only by reset

Behaviour:
- Reset values: all outputs 0; FSM in IDLE (so ex_ready=1 after reset); timeout counter 0.
- Accept condition: ex_valid & ex_ready at a rising edge. The stage latches all inputs into internal registers.
- FSM states: IDLE, ACCESS.
- IDLE transitions on accept:
  - If mem_read|mem_write and alu_result[2:0]==0: go to ACCESS.
  - If mem_read|mem_write and alu_result[2:0]!=0 (misaligned): set mem_fault. Drop the instruction with no wb_valid and no request. Stay in IDLE.
  - Otherwise (non-memory): next cycle wb_valid=1 with wb_data=alu_result. Latency is 1.
- mem_read and mem_write both high: treated as a store.
- Branch resolution on every accepted instruction, registered:
  - pc_src=1 for exactly the cycle after accept when uncond_branch | (branch & zero).
  - pc_target=branch_target in that cycle.
  - A misaligned memory op still resolves its branch bits.
- ACCESS:
  - dmem_req=1, with dmem_we/addr/wdata driven from the latched values, constant throughout.
  - ex_ready=0.
  - Counter increments each cycle in ACCESS.
  - dmem_ack=1: capture dmem_rdata and return to IDLE. Next cycle wb_valid=1, wb_data=load data (mem_to_reg) else alu_result.
  - Store completes with wb_valid=1 and wb_reg_write=0 unless reg_write was set.
- Timeout: if the counter reaches TIMEOUT-1 with no ack, set mem_fault, drop dmem_req, return to IDLE, and emit no wb_valid. The counter clears on leaving ACCESS.
- An ack arriving in the same cycle as timeout expiry wins; no fault is raised.
- dmem_ack while dmem_req=0 is ignored.
- wb_rd and wb_reg_write are registered copies of the latched rd and reg_write. wb_reg_write=reg_write & wb_valid.
- Throughput: back-to-back non-memory instructions are accepted every cycle. A memory op takes a minimum of 2 cycles (req cycle + ack).
- Reset mid-ACCESS: dmem_req drops immediately (asynchronous), FSM returns to IDLE, the in-flight instruction is discarded, and mem_fault is cleared.

Test Plan:
1. ADD, alu_result=0x2A, reg_write=1, rd=3 -> next cycle wb_valid=1, wb_data=0x2A, wb_rd=3, wb_reg_write=1; ex_ready stays 1.
2. Load, addr=0x100, ack on 3rd ACCESS cycle with rdata=0xDEADBEEF, mem_to_reg=1 -> dmem_req high 3 cycles, ex_ready low for those 3 cycles, then wb_data=0xDEADBEEF.
3. Store, addr=0x08, write_data=0x55, immediate ack -> dmem_we=1 for 1 cycle, wb_valid=1, wb_reg_write=0.
4. CBZ with zero=1, branch_target=0x400, then with zero=0 -> first gives pc_src=1 with pc_target=0x400 for one cycle; second gives pc_src=0.
5. Load, addr=0x103 -> no dmem_req, mem_fault=1 and remains set; load, addr=0x200 with no ack -> after 16 cycles dmem_req drops, no wb_valid.
6. Assert reset during ACCESS, then ack -> dmem_req=0 immediately, mem_fault=0, ack ignored, no wb_valid.
